// File: rtl/ps2_number_entry.sv
// PS/2 set-2 number entry: collects decimal keystrokes as BCD, supports
// backspace/escape/enter, and converts the entry to binary one digit per cycle.
module ps2_number_entry #(
  parameter int unsigned MAX_DIGITS = 9
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              ps2_byte,
  input  logic                    ps2_byte_valid,
  input  logic                    num_ack,
  output logic [31:0]             num_buffer,
  output logic                    num_valid,
  output logic [4*MAX_DIGITS-1:0] entry_bcd,
  output logic [3:0]              digit_count,
  output logic                    busy,
  output logic                    overrun
);

  localparam int unsigned BCD_W   = 4 * MAX_DIGITS;
  localparam int unsigned ACC_W   = 32;
  localparam logic [3:0]  MAX_CNT = 4'(MAX_DIGITS);

  localparam logic [7:0] KEY_BREAK = 8'hF0;
  localparam logic [7:0] KEY_EXT   = 8'hE0;
  localparam logic [7:0] KEY_ENTER = 8'h5A;
  localparam logic [7:0] KEY_BKSP  = 8'h66;
  localparam logic [7:0] KEY_ESC   = 8'h76;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXT,
    S_BREAK,
    S_CONVERT
  } state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [3:0]       idx;

  logic             digit_hit;
  logic [3:0]       digit_val;
  logic [3:0]       conv_digit;
  logic [ACC_W-1:0] acc_next;
  logic             enter_req;

  // Decode a make code into a decimal digit value.
  always_comb begin
    digit_hit = 1'b1;
    digit_val = 4'd0;
    case (ps2_byte)
      8'h45:   digit_val = 4'd0;
      8'h16:   digit_val = 4'd1;
      8'h1E:   digit_val = 4'd2;
      8'h26:   digit_val = 4'd3;
      8'h25:   digit_val = 4'd4;
      8'h2E:   digit_val = 4'd5;
      8'h36:   digit_val = 4'd6;
      8'h3D:   digit_val = 4'd7;
      8'h3E:   digit_val = 4'd8;
      8'h46:   digit_val = 4'd9;
      default: digit_hit = 1'b0;
    endcase
  end

  // Conversion datapath: acc*10 + current digit, most-significant digit first.
  always_comb begin
    conv_digit = 4'(entry_bcd >> {idx, 2'b00});
    acc_next   = (acc << 3) + (acc << 1) + ACC_W'(conv_digit);
  end

  // Enter arrives either as a plain make code or behind the E0 prefix.
  always_comb begin
    enter_req = ps2_byte_valid && (ps2_byte == KEY_ENTER) &&
                ((state == S_IDLE) || (state == S_EXT));
  end

  // Key decoding FSM, entry buffer, conversion and handshake registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      acc         <= '0;
      idx         <= '0;
      num_buffer  <= '0;
      num_valid   <= 1'b0;
      entry_bcd   <= '0;
      digit_count <= '0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (num_ack) begin
        num_valid <= 1'b0;
        overrun   <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (ps2_byte_valid) begin
            if (ps2_byte == KEY_BREAK) begin
              state <= S_BREAK;
            end else if (ps2_byte == KEY_EXT) begin
              state <= S_EXT;
            end else if (digit_hit) begin
              if (digit_count < MAX_CNT) begin
                entry_bcd   <= {entry_bcd[BCD_W-5:0], digit_val};
                digit_count <= digit_count + 4'd1;
              end
            end else if (ps2_byte == KEY_BKSP) begin
              if (digit_count != 4'd0) begin
                entry_bcd   <= entry_bcd >> 4;
                digit_count <= digit_count - 4'd1;
              end
            end else if (ps2_byte == KEY_ESC) begin
              entry_bcd   <= '0;
              digit_count <= '0;
            end
          end
        end
        S_EXT: begin
          if (ps2_byte_valid) begin
            state <= (ps2_byte == KEY_BREAK) ? S_BREAK : S_IDLE;
          end
        end
        S_BREAK: begin
          if (ps2_byte_valid) begin
            state <= S_IDLE;
          end
        end
        S_CONVERT: begin
          acc <= acc_next;
          idx <= idx - 4'd1;
          if (idx == 4'd0) begin
            num_buffer  <= acc_next;
            num_valid   <= 1'b1;
            overrun     <= 1'b0;
            entry_bcd   <= '0;
            digit_count <= '0;
            busy        <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase

      // Enter overrides the EXT return-to-IDLE when a conversion starts.
      if (enter_req && (digit_count != 4'd0)) begin
        if (num_valid && !num_ack) begin
          overrun <= 1'b1;
        end else begin
          state <= S_CONVERT;
          busy  <= 1'b1;
          acc   <= '0;
          idx   <= digit_count - 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_number_entry.sv
// Self-checking bench for ps2_number_entry: directed scenarios plus random
// keystreams against a digit-list reference model.
module tb_ps2_number_entry;

  localparam int unsigned MAX_DIGITS = 9;
  localparam int unsigned BCD_W      = 4 * MAX_DIGITS;

  logic              clk;
  logic              rst;
  logic [7:0]        ps2_byte;
  logic              ps2_byte_valid;
  logic              num_ack;
  logic [31:0]       num_buffer;
  logic              num_valid;
  logic [BCD_W-1:0]  entry_bcd;
  logic [3:0]        digit_count;
  logic              busy;
  logic              overrun;

  ps2_number_entry #(.MAX_DIGITS(MAX_DIGITS)) dut (
    .clk           (clk),
    .rst           (rst),
    .ps2_byte      (ps2_byte),
    .ps2_byte_valid(ps2_byte_valid),
    .num_ack       (num_ack),
    .num_buffer    (num_buffer),
    .num_valid     (num_valid),
    .entry_bcd     (entry_bcd),
    .digit_count   (digit_count),
    .busy          (busy),
    .overrun       (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: the entry is a list of decimal digits, oldest first.
  int          m_digits[$];
  bit          m_after_f0;
  bit          m_after_e0;
  int          m_conv_left;
  longint      m_pending;
  logic [31:0] m_buf;
  bit          m_valid;
  bit          m_ovr;

  logic [7:0] key_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                                 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

  function automatic int digit_of(input logic [7:0] b);
    for (int i = 0; i < 10; i++) if (key_codes[i] == b) return i;
    return -1;
  endfunction

  function automatic logic [BCD_W-1:0] model_bcd();
    logic [BCD_W-1:0] r = '0;
    foreach (m_digits[i]) r = (r << 4) | BCD_W'(m_digits[i]);
    return r;
  endfunction

  task automatic model_reset();
    m_digits.delete();
    m_after_f0  = 0;
    m_after_e0  = 0;
    m_conv_left = 0;
    m_pending   = 0;
    m_buf       = '0;
    m_valid     = 0;
    m_ovr       = 0;
  endtask

  task automatic model_enter(input bit old_valid, input bit ack);
    longint v = 0;
    if (m_digits.size() == 0) return;
    if (old_valid && !ack) begin
      m_ovr = 1;
      return;
    end
    foreach (m_digits[i]) v = v * 10 + m_digits[i];
    m_pending   = v;
    m_conv_left = m_digits.size();
  endtask

  // Advance the model by one clock edge with the given inputs.
  task automatic model_step(input bit v, input logic [7:0] b, input bit ack);
    bit old_valid = m_valid;
    int d;
    if (m_conv_left > 0) begin
      m_conv_left--;
      if (m_conv_left == 0) begin
        m_buf   = 32'(m_pending);
        m_valid = 1;
        m_ovr   = 0;
        m_digits.delete();
      end else if (ack) begin
        m_valid = 0;
        m_ovr   = 0;
      end
      return;
    end
    if (ack) begin
      m_valid = 0;
      m_ovr   = 0;
    end
    if (!v) return;
    if (m_after_f0) begin
      m_after_f0 = 0;
    end else if (m_after_e0) begin
      m_after_e0 = 0;
      if (b == 8'hF0) m_after_f0 = 1;
      else if (b == 8'h5A) model_enter(old_valid, ack);
    end else if (b == 8'hF0) begin
      m_after_f0 = 1;
    end else if (b == 8'hE0) begin
      m_after_e0 = 1;
    end else if (b == 8'h5A) begin
      model_enter(old_valid, ack);
    end else if (b == 8'h66) begin
      if (m_digits.size() > 0) void'(m_digits.pop_back());
    end else if (b == 8'h76) begin
      m_digits.delete();
    end else begin
      d = digit_of(b);
      if (d >= 0 && m_digits.size() < MAX_DIGITS) m_digits.push_back(d);
    end
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every DUT output with the model.
  task automatic compare_all();
    check("num_buffer",  longint'(num_buffer),  longint'(m_buf));
    check("num_valid",   longint'(num_valid),   longint'(m_valid));
    check("entry_bcd",   longint'(entry_bcd),   longint'(model_bcd()));
    check("digit_count", longint'(digit_count), longint'(m_digits.size()));
    check("busy",        longint'(busy),        longint'(m_conv_left > 0));
    check("overrun",     longint'(overrun),     longint'(m_ovr));
  endtask

  task automatic step(input bit v, input logic [7:0] b, input bit ack);
    @(negedge clk);
    compare_all();
    ps2_byte_valid = v;
    ps2_byte       = b;
    num_ack        = ack;
    @(posedge clk);
    model_step(v, b, ack);
    #1;
    ps2_byte_valid = 1'b0;
    num_ack        = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b1, b, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic ack_pulse();
    step(1'b0, 8'h00, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    compare_all();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  initial begin
    rst            = 1'b0;
    ps2_byte       = 8'h00;
    ps2_byte_valid = 1'b0;
    num_ack        = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_buffer", longint'(num_buffer), 0);
    check("reset_count",  longint'(digit_count), 0);
    check("reset_busy",   longint'(busy), 0);
    @(negedge clk);
    rst = 1'b1;

    // Digit entry and commit of 123.
    send(8'h16); send(8'h1E); send(8'h26);
    check("t1_count", longint'(digit_count), 3);
    check("t1_bcd",   longint'(entry_bcd), 64'h123);
    send(8'h5A);
    check("t1_busy", longint'(busy), 1);
    idle(2);
    check("t1_not_yet", longint'(num_valid), 0);
    idle(1);
    check("t1_buffer", longint'(num_buffer), 123);
    check("t1_valid",  longint'(num_valid), 1);
    check("t1_clear",  longint'(digit_count), 0);
    ack_pulse();
    check("t1_ack_valid", longint'(num_valid), 0);
    check("t1_ack_hold",  longint'(num_buffer), 123);

    // Break and extended prefixes, keypad enter.
    send(8'h16); send(8'hF0); send(8'h16); send(8'hE0); send(8'hF0);
    send(8'h5A); send(8'h1E); send(8'hE0); send(8'h5A);
    idle(2);
    check("t2_buffer", longint'(num_buffer), 12);
    ack_pulse();

    // Editing: backspace and escape.
    send(8'h16); send(8'h1E); send(8'h66); send(8'h26);
    check("t3_bcd", longint'(entry_bcd), 64'h13);
    send(8'h76); send(8'h3D); send(8'h45); send(8'h5A);
    idle(2);
    check("t3_buffer", longint'(num_buffer), 70);
    ack_pulse();

    // Digit limit and maximum value.
    for (int i = 0; i < 10; i++) send(8'h46);
    check("t4_count", longint'(digit_count), 9);
    send(8'h5A);
    idle(8);
    check("t4_busy8", longint'(busy), 1);
    idle(1);
    check("t4_buffer", longint'(num_buffer), 64'h3B9AC9FF);
    check("t4_idle",   longint'(busy), 0);
    ack_pulse();
    send(8'h5A);
    check("t4_empty_enter", longint'(busy), 0);

    // Overrun and ack collisions.
    send(8'h2E); send(8'h5A); idle(1);
    check("t5_first", longint'(num_buffer), 5);
    send(8'h3E); send(8'h5A);
    check("t5_overrun", longint'(overrun), 1);
    check("t5_kept",    longint'(entry_bcd), 8);
    step(1'b1, 8'h5A, 1'b1);
    check("t5_accept", longint'(busy), 1);
    idle(1);
    check("t5_second", longint'(num_buffer), 8);
    ack_pulse();
    send(8'h16); send(8'h1E); send(8'h5A); idle(1);
    step(1'b0, 8'h00, 1'b1);
    check("t5_commit_wins", longint'(num_valid), 1);
    check("t5_commit_val",  longint'(num_buffer), 12);

    // Bytes during CONVERT are dropped.
    ack_pulse();
    send(8'h1E); send(8'h1E); send(8'h5A); send(8'h16); idle(1);
    check("t6_dropped", longint'(digit_count), 0);
    check("t6_value",   longint'(num_buffer), 22);

    // Reset during CONVERT.
    send(8'h25); send(8'h2E); send(8'h36); send(8'h5A); send(8'h16);
    do_reset();
    check("t6_rst_buffer", longint'(num_buffer), 0);
    check("t6_rst_busy",   longint'(busy), 0);
    idle(4);
    check("t6_no_commit", longint'(num_valid), 0);

    // Random keystreams.
    for (int i = 0; i < 3000; i++) begin
      int sel = $urandom_range(0, 99);
      logic [7:0] b;
      if (sel < 55)      b = key_codes[$urandom_range(0, 9)];
      else if (sel < 63) b = 8'h5A;
      else if (sel < 70) b = 8'h66;
      else if (sel < 73) b = 8'h76;
      else if (sel < 81) b = 8'hF0;
      else if (sel < 88) b = 8'hE0;
      else               b = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 499) == 0) do_reset();
      else step(1'($urandom_range(0, 1)), b, ($urandom_range(0, 9) == 0));
    end
    idle(12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
